// File: rtl/time_display_scan_if.sv
// Digit, blink-control and display-bus signals shared by the clock core and the scanner.
// master drives the BCD digits and blink requests; slave drives the multiplexed display.
interface time_display_scan_if;
  logic [3:0] hh_t_in;
  logic [3:0] hh_u_in;
  logic [3:0] mm_t_in;
  logic [3:0] mm_u_in;
  logic [3:0] ss_t_in;
  logic [3:0] ss_u_in;
  logic       blink_hr;
  logic       blink_min;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output hh_t_in, hh_u_in, mm_t_in, mm_u_in, ss_t_in, ss_u_in, blink_hr, blink_min,
    input  an, seg, dp
  );

  modport slave (
    input  hh_t_in, hh_u_in, mm_t_in, mm_u_in, ss_t_in, ss_u_in, blink_hr, blink_min,
    output an, seg, dp
  );
endinterface

// File: rtl/time_display_scan.sv
// Six-digit common-anode 7-segment scanner with per-frame digit snapshot,
// set-mode field blinking, leading-zero blanking and a blinking colon.
module time_display_scan #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 500000,
  parameter bit          LZB       = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  time_display_scan_if.slave  bus
);

  localparam int unsigned ScanW  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ScanW-1:0]  ScanMax  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);
  localparam logic [6:0] SegBlank = 7'b1111111;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  logic              active_q;
  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  // Snapshot order: [0]=ss_u .. [5]=hh_t, matching the anode order.
  logic [5:0][3:0]   snap_q, snap_d;
  logic [5:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        digit;
  logic              blank;

  always_comb begin
    scan_cnt_d  = scan_cnt_q;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    snap_d      = snap_q;

    if (!active_q) begin
      // First active edge: restart the frame with a fresh snapshot.
      scan_cnt_d  = '0;
      idx_d       = 3'd0;
      blink_cnt_d = '0;
      phase_d     = 1'b0;
      snap_d      = {bus.hh_t_in, bus.hh_u_in, bus.mm_t_in, bus.mm_u_in,
                     bus.ss_t_in, bus.ss_u_in};
    end else begin
      if (scan_cnt_q == ScanMax) begin
        scan_cnt_d = '0;
        if (idx_q == 3'd5) begin
          idx_d  = 3'd0;
          snap_d = {bus.hh_t_in, bus.hh_u_in, bus.mm_t_in, bus.mm_u_in,
                    bus.ss_t_in, bus.ss_u_in};
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        scan_cnt_d = scan_cnt_q + ScanW'(1);
      end

      if (blink_cnt_q == BlinkMax) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end
    end
  end

  // Outputs are computed from next-state so they switch on the same edge as idx.
  always_comb begin
    digit = 4'd0;
    case (idx_d)
      3'd0:    digit = snap_d[0];
      3'd1:    digit = snap_d[1];
      3'd2:    digit = snap_d[2];
      3'd3:    digit = snap_d[3];
      3'd4:    digit = snap_d[4];
      3'd5:    digit = snap_d[5];
      default: digit = 4'd0;
    endcase

    blank = 1'b0;
    if (phase_d && bus.blink_hr && (idx_d == 3'd4 || idx_d == 3'd5)) blank = 1'b1;
    if (phase_d && bus.blink_min && (idx_d == 3'd2 || idx_d == 3'd3)) blank = 1'b1;
    if (LZB && idx_d == 3'd5 && digit == 4'd0) blank = 1'b1;

    an_d  = ~(6'b000001 << idx_d);
    seg_d = blank ? SegBlank : decode(digit);
    dp_d  = ~((idx_d == 3'd2 || idx_d == 3'd4) && !phase_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q    <= 1'b0;
      scan_cnt_q  <= '0;
      idx_q       <= 3'd0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      snap_q      <= '0;
      an_q        <= 6'b111111;
      seg_q       <= SegBlank;
      dp_q        <= 1'b1;
    end else begin
      active_q    <= 1'b1;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      snap_q      <= snap_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan with SCAN_DIV=4, BLINK_DIV=64, LZB=1.
// After edge n (n>=1) of a run: idx=((n-1)/4)%6, phase=((n-1)/64)%2.
module tb_time_display_scan;

  localparam logic [6:0] SEG0  = 7'b1000000;
  localparam logic [6:0] SEG1  = 7'b1111001;
  localparam logic [6:0] SEG2  = 7'b0100100;
  localparam logic [6:0] SEG3  = 7'b0110000;
  localparam logic [6:0] SEG4  = 7'b0011001;
  localparam logic [6:0] SEG5  = 7'b0010010;
  localparam logic [6:0] SEG6  = 7'b0000010;
  localparam logic [6:0] SEG7  = 7'b1111000;
  localparam logic [6:0] SEG8  = 7'b0000000;
  localparam logic [6:0] SEG9  = 7'b0010000;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk;
  logic rst;
  int   edge_n;
  int   n_assert;
  int   n_fail;

  time_display_scan_if bus ();

  time_display_scan #(
    .SCAN_DIV  (4),
    .BLINK_DIV (64),
    .LZB       (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_to(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic chk(input string tag, input logic [5:0] an_e, input logic [6:0] seg_e,
                     input logic dp_e);
    n_assert++;
    assert (bus.an === an_e) else begin
      n_fail++;
      $error("FAIL %s an: got %b want %b", tag, bus.an, an_e);
    end
    n_assert++;
    assert (bus.seg === seg_e) else begin
      n_fail++;
      $error("FAIL %s seg: got %b want %b", tag, bus.seg, seg_e);
    end
    n_assert++;
    assert (bus.dp === dp_e) else begin
      n_fail++;
      $error("FAIL %s dp: got %b want %b", tag, bus.dp, dp_e);
    end
  endtask

  task automatic set_digits(input logic [3:0] ht, input logic [3:0] hu, input logic [3:0] mt,
                            input logic [3:0] mu, input logic [3:0] st, input logic [3:0] su);
    bus.hh_t_in = ht;
    bus.hh_u_in = hu;
    bus.mm_t_in = mt;
    bus.mm_u_in = mu;
    bus.ss_t_in = st;
    bus.ss_u_in = su;
  endtask

  logic [5:0] an_tab  [6];
  logic [6:0] seg_tab [6];
  logic       dp_tab  [6];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    edge_n   = 0;
    an_tab   = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};
    seg_tab  = '{SEG6, SEG5, SEG4, SEG3, SEG2, SEG1};
    dp_tab   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst           = 1'b1;
    bus.blink_hr  = 1'b0;
    bus.blink_min = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);

    #12;
    chk("reset", 6'b111111, BLANK, 1'b1);

    @(posedge clk);
    #1;
    rst    = 1'b0;
    edge_n = 0;

    // Frame 1: 12:34:56, each digit checked on its first and last lit cycle.
    tick_to(1);
    chk("first_edge", 6'b111110, SEG6, 1'b1);
    for (int d = 0; d < 6; d++) begin
      tick_to(4 * d + 1);
      chk($sformatf("scan_start_idx%0d", d), an_tab[d], seg_tab[d], dp_tab[d]);
      tick_to(4 * d + 4);
      chk($sformatf("scan_end_idx%0d", d), an_tab[d], seg_tab[d], dp_tab[d]);
    end

    // Frame 2: change inputs mid-frame; the frame must keep the old snapshot.
    tick_to(25);
    chk("frame2_idx0", 6'b111110, SEG6, 1'b1);
    tick_to(37);
    set_digits(4'd0, 4'd9, 4'd5, 4'd8, 4'd0, 4'hC);
    tick_to(38);
    chk("tear_idx3", 6'b110111, SEG3, 1'b1);
    tick_to(41);
    chk("tear_idx4", 6'b101111, SEG2, 1'b0);
    tick_to(48);
    chk("tear_idx5", 6'b011111, SEG1, 1'b1);

    // Frame 3: new snapshot 09:58:0C; LZB blanks hh_t, C shows dash.
    tick_to(49);
    chk("new_idx0_dash", 6'b111110, DASH, 1'b1);
    tick_to(53);
    chk("new_idx1", 6'b111101, SEG0, 1'b1);
    tick_to(57);
    chk("new_idx2", 6'b111011, SEG8, 1'b0);
    tick_to(64);
    chk("pre_wrap_idx3", 6'b110111, SEG5, 1'b1);
    tick_to(65);
    chk("wrap_collide", 6'b101111, SEG9, 1'b1);
    tick_to(69);
    chk("lzb_idx5", 6'b011111, BLANK, 1'b1);

    // Frame 4: phase=1, minutes blink.
    bus.blink_min = 1'b1;
    tick_to(73);
    chk("bmin_idx0", 6'b111110, DASH, 1'b1);
    tick_to(77);
    chk("bmin_idx1", 6'b111101, SEG0, 1'b1);
    tick_to(81);
    chk("bmin_idx2", 6'b111011, BLANK, 1'b1);
    tick_to(85);
    chk("bmin_idx3", 6'b110111, BLANK, 1'b1);
    tick_to(89);
    chk("bmin_idx4", 6'b101111, SEG9, 1'b1);

    // Frame 5: phase=1, hours blink instead.
    bus.blink_min = 1'b0;
    bus.blink_hr  = 1'b1;
    tick_to(93);
    bus.hh_t_in = 4'd1;
    tick_to(105);
    chk("bhr_idx2", 6'b111011, SEG8, 1'b1);
    tick_to(109);
    chk("bhr_idx3", 6'b110111, SEG5, 1'b1);
    tick_to(113);
    chk("bhr_idx4", 6'b101111, BLANK, 1'b1);
    tick_to(117);
    chk("bhr_idx5", 6'b011111, BLANK, 1'b1);

    // Frame 6: phase back to 0 at edge 129, hours visible despite blink_hr.
    tick_to(121);
    chk("f6_idx0", 6'b111110, DASH, 1'b1);
    tick_to(129);
    chk("phase0_idx2", 6'b111011, SEG8, 1'b0);
    tick_to(137);
    chk("phase0_idx4", 6'b101111, SEG9, 1'b0);
    tick_to(141);
    chk("hh_t_one_idx5", 6'b011111, SEG1, 1'b1);

    // Asynchronous reset mid-digit, then restart with a fresh snapshot.
    tick_to(142);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 6'b111111, BLANK, 1'b1);
    bus.blink_hr = 1'b0;
    bus.ss_u_in  = 4'd7;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_held", 6'b111111, BLANK, 1'b1);
    rst    = 1'b0;
    edge_n = 0;
    tick_to(1);
    chk("restart_idx0", 6'b111110, SEG7, 1'b1);
    tick_to(5);
    chk("restart_idx1", 6'b111101, SEG0, 1'b1);
    tick_to(9);
    chk("restart_idx2", 6'b111011, SEG8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
